// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates icache fetches against LSB loads/stores and
// serialises each request into byte accesses on the 8-bit RAM/IO bus.
module mem_ctrl #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,

    input  logic        icache_to_memctrl,
    input  logic [31:0] address,
    output logic        received,
    output logic        memctrl_to_icache,
    output logic [31:0] inst_in,

    input  logic        lsb_to_memctrl,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_data,
    output logic        lsb_received,
    output logic        memctrl_to_lsb,
    output logic [31:0] lsb_result,

    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    localparam logic [2:0] WORD_LEN = 3'd4;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] acc;
    logic [2:0]  len;
    logic [2:0]  cnt;
    logic        is_lsb;
    logic        is_wr;
    logic        rdy_q;
    logic [7:0]  din_hold;
    logic        committed;

    logic [2:0]  cnt_inc;
    logic [1:0]  cap_idx;
    logic [7:0]  din_eff;
    logic [31:0] acc_merged;
    logic [2:0]  wr_idx;
    logic [31:0] wr_addr;
    logic [7:0]  wr_byte;
    logic        wr_stall;
    logic        acc_stall;
    logic [31:0] rd_next_a;

    function automatic logic [2:0] size_len(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return WORD_LEN;
        endcase
    endfunction

    // Byte capture and next-issue datapath.  The RAM keeps reading while paused,
    // so the byte that was due at the first paused edge is parked in din_hold.
    always_comb begin
        cnt_inc    = cnt + 3'd1;
        cap_idx    = 2'(cnt - 3'd1);
        din_eff    = rdy_q ? mem_din : din_hold;
        acc_merged = acc;
        acc_merged[{cap_idx, 3'b000} +: 8] = din_eff;
        wr_idx     = (mem_wr || committed) ? cnt_inc : cnt;
        wr_addr    = base + 32'(wr_idx);
        wr_byte    = wdata[{wr_idx[1:0], 3'b000} +: 8];
        wr_stall   = io_buffer_full && (wr_addr[17:16] == IO_HI);
        acc_stall  = io_buffer_full && (lsb_addr[17:16] == IO_HI);
        rd_next_a  = (cnt_inc < len) ? base + 32'(cnt_inc) : 32'd0;
    end

    // Controller FSM with registered bus and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            base              <= '0;
            wdata             <= '0;
            acc               <= '0;
            len               <= '0;
            cnt               <= '0;
            is_lsb            <= 1'b0;
            is_wr             <= 1'b0;
            rdy_q             <= 1'b0;
            din_hold          <= '0;
            committed         <= 1'b0;
            received          <= 1'b0;
            memctrl_to_icache <= 1'b0;
            inst_in           <= '0;
            lsb_received      <= 1'b0;
            memctrl_to_lsb    <= 1'b0;
            lsb_result        <= '0;
            mem_dout          <= '0;
            mem_a             <= '0;
            mem_wr            <= 1'b0;
        end else begin
            rdy_q <= rdy;
            if (rdy_q) begin
                din_hold <= mem_din;
            end
            if (!rdy) begin
                // A write on the bus at the pausing edge lands in RAM; remember it.
                mem_wr <= 1'b0;
                if (mem_wr) begin
                    committed <= 1'b1;
                end
            end else begin
                committed         <= 1'b0;
                received          <= 1'b0;
                memctrl_to_icache <= 1'b0;
                lsb_received      <= 1'b0;
                memctrl_to_lsb    <= 1'b0;
                case (state)
                    IDLE: begin
                        mem_wr   <= 1'b0;
                        mem_a    <= '0;
                        mem_dout <= '0;
                        if (lsb_to_memctrl) begin
                            state        <= BUSY;
                            lsb_received <= 1'b1;
                            is_lsb       <= 1'b1;
                            is_wr        <= lsb_wr;
                            base         <= lsb_addr;
                            wdata        <= lsb_data;
                            len          <= size_len(lsb_size);
                            cnt          <= '0;
                            acc          <= '0;
                            mem_a        <= lsb_addr;
                            if (lsb_wr) begin
                                mem_dout <= lsb_data[7:0];
                                mem_wr   <= !acc_stall;
                            end
                        end else if (icache_to_memctrl) begin
                            state    <= BUSY;
                            received <= 1'b1;
                            is_lsb   <= 1'b0;
                            is_wr    <= 1'b0;
                            base     <= address;
                            wdata    <= '0;
                            len      <= WORD_LEN;
                            cnt      <= '0;
                            acc      <= '0;
                            mem_a    <= address;
                        end
                    end
                    BUSY: begin
                        if (is_wr) begin
                            if ((mem_wr || committed) && (cnt_inc == len)) begin
                                state          <= IDLE;
                                memctrl_to_lsb <= 1'b1;
                                mem_wr         <= 1'b0;
                                mem_a          <= '0;
                                mem_dout       <= '0;
                            end else begin
                                cnt      <= wr_idx;
                                mem_a    <= wr_addr;
                                mem_dout <= wr_byte;
                                mem_wr   <= !wr_stall;
                            end
                        end else begin
                            mem_wr <= 1'b0;
                            if (cnt != 3'd0) begin
                                acc <= acc_merged;
                            end
                            if (cnt == len) begin
                                state <= IDLE;
                                mem_a <= '0;
                                if (is_lsb) begin
                                    memctrl_to_lsb <= 1'b1;
                                    lsb_result     <= acc_merged;
                                end else begin
                                    memctrl_to_icache <= 1'b1;
                                    inst_in           <= acc_merged;
                                end
                            end else begin
                                cnt   <= cnt_inc;
                                mem_a <= rd_next_a;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-addressed RAM model plus a
// transaction-level reference of expected results and latencies.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        icache_to_memctrl;
    logic [31:0] address;
    logic        received, memctrl_to_icache;
    logic [31:0] inst_in;
    logic        lsb_to_memctrl, lsb_wr;
    logic [31:0] lsb_addr;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_data;
    logic        lsb_received, memctrl_to_lsb;
    logic [31:0] lsb_result;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.IO_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .icache_to_memctrl(icache_to_memctrl), .address(address),
        .received(received), .memctrl_to_icache(memctrl_to_icache), .inst_in(inst_in),
        .lsb_to_memctrl(lsb_to_memctrl), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr),
        .lsb_size(lsb_size), .lsb_data(lsb_data), .lsb_received(lsb_received),
        .memctrl_to_lsb(memctrl_to_lsb), .lsb_result(lsb_result),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // 64 KiB RAM aliased over the 32-bit space; back-door port for preloading.
    bit   [7:0]  ram     [0:65535];
    bit   [7:0]  ref_mem [0:65535];
    logic        poke_en;
    logic [15:0] poke_a;
    logic [7:0]  poke_d;

    always @(posedge clk) begin
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
        else if (poke_en) ram[poke_a] <= poke_d;
    end

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_a = a; poke_d = d; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
        ref_mem[a] = d;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] t = a + 32'(i);
            v = v | (32'(ref_mem[t[15:0]]) << (8 * i));
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            logic [31:0] t = a + 32'(i);
            ref_mem[t[15:0]] = 8'(d >> (8 * i));
        end
    endtask

    // Observations of the last transaction
    logic [31:0] a_log[$];
    logic [39:0] w_log[$];
    int          lat, first_wr;
    logic [31:0] res;
    logic        acc_ok, overlap;
    int          io_cycles = 0;
    int          pause_at  = -1;
    int          pause_len = 0;
    int          rst_at    = -1;

    // Issue one request; cycle 0 is the cycle after the accepting edge.
    task automatic txn(input bit lsb, input bit wr, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] d);
        a_log.delete(); w_log.delete();
        lat = -1; first_wr = -1; res = '0; overlap = 1'b0;
        if (lsb) begin
            lsb_to_memctrl = 1'b1; lsb_wr = wr; lsb_addr = a; lsb_size = sz; lsb_data = d;
        end else begin
            icache_to_memctrl = 1'b1; address = a;
        end
        if (io_cycles > 0) io_buffer_full = 1'b1;
        @(posedge clk); #1;
        acc_ok = lsb ? (lsb_received && !received) : (received && !lsb_received);
        lsb_to_memctrl = 1'b0; icache_to_memctrl = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (received && memctrl_to_icache) overlap = 1'b1;
            if (c > 0 && (lsb ? memctrl_to_lsb : memctrl_to_icache)) begin
                lat = c;
                res = lsb ? lsb_result : inst_in;
                break;
            end
            a_log.push_back(mem_a);
            if (mem_wr) begin
                w_log.push_back({mem_a, mem_dout});
                if (first_wr < 0) first_wr = c;
            end
            if (c == io_cycles - 1) io_buffer_full = 1'b0;
            if (c == pause_at) rdy = 1'b0;
            if (c == pause_at + pause_len) rdy = 1'b1;
            if (c == rst_at) rst = 1'b1;
            if (c == rst_at + 1) rst = 1'b0;
            @(posedge clk); #1;
        end
        io_buffer_full = 1'b0; rdy = 1'b1; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({received, memctrl_to_icache, lsb_received, memctrl_to_lsb, mem_wr} !== 5'b0) begin
            errors++; $display("FAIL reset_pulses got %b want 00000",
                {received, memctrl_to_icache, lsb_received, memctrl_to_lsb, mem_wr});
        end
        vectors++;
        if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin
            errors++; $display("FAIL reset_bus got a=%h d=%h want 0", mem_a, mem_dout);
        end
        vectors++;
        if (inst_in !== 32'h0 || lsb_result !== 32'h0) begin
            errors++; $display("FAIL reset_results got %h %h want 0", inst_in, lsb_result);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        poke(16'h0100, 8'h13); poke(16'h0101, 8'h05); poke(16'h0102, 8'h00); poke(16'h0103, 8'h00);
        txn(1'b0, 1'b0, 32'h100, 2'b10, 32'h0);
        vectors++;
        if (acc_ok !== 1'b1) begin errors++; $display("FAIL fetch_received got %b want 1", acc_ok); end
        for (int k = 0; k < 4; k++) begin
            logic [31:0] got = (k < a_log.size()) ? a_log[k] : 32'hxxxxxxxx;
            vectors++;
            if (got !== 32'h100 + 32'(k)) begin
                errors++; $display("FAIL fetch_addr%0d got %h want %h", k, got, 32'h100 + 32'(k));
            end
        end
        vectors++;
        if (lat !== 5) begin errors++; $display("FAIL fetch_latency got %0d want 5", lat); end
        vectors++;
        if (res !== 32'h00000513) begin errors++; $display("FAIL fetch_data got %h want 00000513", res); end
        vectors++;
        if (w_log.size() !== 0 || overlap !== 1'b0) begin
            errors++; $display("FAIL fetch_nowrite got writes=%0d overlap=%b want 0 0", w_log.size(), overlap);
        end
    endtask

    task automatic test_arbitration();
        int lp = -1, rc = -1, ic = -1;
        logic [31:0] lres = '0;
        poke(16'h0200, 8'hAB);
        poke(16'h0300, 8'h78); poke(16'h0301, 8'h56); poke(16'h0302, 8'h34); poke(16'h0303, 8'h12);
        lsb_to_memctrl = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h200; lsb_size = 2'b00;
        icache_to_memctrl = 1'b1; address = 32'h300;
        @(posedge clk); #1;
        vectors++;
        if ({lsb_received, received} !== 2'b10) begin
            errors++; $display("FAIL arb_winner got lsb=%b ic=%b want 1 0", lsb_received, received);
        end
        lsb_to_memctrl = 1'b0;
        for (int c = 1; c < 40; c++) begin
            @(posedge clk); #1;
            if (memctrl_to_lsb && lp < 0) begin lp = c; lres = lsb_result; end
            if (received) begin rc = c; icache_to_memctrl = 1'b0; break; end
        end
        icache_to_memctrl = 1'b0;
        vectors++;
        if (lp !== 2 || lres !== 32'h000000AB) begin
            errors++; $display("FAIL arb_load got lat=%0d data=%h want 2 000000ab", lp, lres);
        end
        vectors++;
        if (rc !== lp + 1) begin errors++; $display("FAIL arb_icache_accept got %0d want %0d", rc, lp + 1); end
        for (int c = 1; c < 40; c++) begin
            @(posedge clk); #1;
            if (memctrl_to_icache) begin ic = c; break; end
        end
        vectors++;
        if (ic !== 5 || inst_in !== 32'h12345678) begin
            errors++; $display("FAIL arb_fetch got lat=%0d data=%h want 5 12345678", ic, inst_in);
        end
    endtask

    task automatic test_store_word();
        txn(1'b1, 1'b1, 32'h1002, 2'b10, 32'hDEADBEEF);
        ref_store(32'h1002, 4, 32'hDEADBEEF);
        vectors++;
        if (lat !== 4 || w_log.size() !== 4) begin
            errors++; $display("FAIL store_timing got lat=%0d writes=%0d want 4 4", lat, w_log.size());
        end
        for (int k = 0; k < 4 && k < w_log.size(); k++) begin
            logic [39:0] want = {32'h1002 + 32'(k), 8'(32'hDEADBEEF >> (8 * k))};
            vectors++;
            if (w_log[k] !== want) begin errors++; $display("FAIL store_byte%0d got %h want %h", k, w_log[k], want); end
        end
        txn(1'b1, 1'b0, 32'h1002, 2'b10, 32'h0);
        vectors++;
        if (lat !== 5 || res !== ref_load(32'h1002, 4)) begin
            errors++; $display("FAIL store_readback got lat=%0d data=%h want 5 %h", lat, res, ref_load(32'h1002, 4));
        end
    endtask

    task automatic test_io_stall();
        io_cycles = 3;
        txn(1'b1, 1'b1, 32'h30000, 2'b00, 32'h41);
        ref_store(32'h30000, 1, 32'h41);
        vectors++;
        if (first_wr !== 3 || w_log.size() !== 1) begin
            errors++; $display("FAIL io_stall got first_wr=%0d writes=%0d want 3 1", first_wr, w_log.size());
        end
        vectors++;
        if (lat !== 4 || (w_log.size() > 0 && w_log[0] !== {32'h30000, 8'h41})) begin
            errors++; $display("FAIL io_write got lat=%0d want 4", lat);
        end
        txn(1'b1, 1'b1, 32'h20010, 2'b00, 32'h55);
        ref_store(32'h20010, 1, 32'h55);
        vectors++;
        if (lat !== 1 || first_wr !== 0) begin
            errors++; $display("FAIL io_nonio got lat=%0d first_wr=%0d want 1 0", lat, first_wr);
        end
        txn(1'b1, 1'b0, 32'h30000, 2'b00, 32'h0);
        vectors++;
        if (lat !== 2 || res !== 32'h41) begin
            errors++; $display("FAIL io_read got lat=%0d data=%h want 2 00000041", lat, res);
        end
        io_cycles = 0;
    endtask

    task automatic test_wrap();
        poke(16'hFFFE, 8'h11); poke(16'hFFFF, 8'h22); poke(16'h0000, 8'h33); poke(16'h0001, 8'h44);
        txn(1'b0, 1'b0, 32'hFFFFFFFE, 2'b10, 32'h0);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] want = 32'hFFFFFFFE + 32'(k);
            logic [31:0] got  = (k < a_log.size()) ? a_log[k] : 32'hxxxxxxxx;
            vectors++;
            if (got !== want) begin errors++; $display("FAIL wrap_addr%0d got %h want %h", k, got, want); end
        end
        vectors++;
        if (res !== 32'h44332211) begin errors++; $display("FAIL wrap_data got %h want 44332211", res); end
    endtask

    task automatic test_pause_and_reset();
        pause_at = 1; pause_len = 2;
        txn(1'b0, 1'b0, 32'h100, 2'b10, 32'h0);
        vectors++;
        if (lat !== 7 || res !== 32'h00000513) begin
            errors++; $display("FAIL pause_read got lat=%0d data=%h want 7 00000513", lat, res);
        end
        txn(1'b1, 1'b1, 32'h0400, 2'b10, 32'hCAFEF00D);
        ref_store(32'h0400, 4, 32'hCAFEF00D);
        pause_at = -1; pause_len = 0;
        vectors++;
        if (lat !== 6 || w_log.size() !== 4) begin
            errors++; $display("FAIL pause_write got lat=%0d writes=%0d want 6 4", lat, w_log.size());
        end
        vectors++;
        if ({ram[16'h403], ram[16'h402], ram[16'h401], ram[16'h400]} !== 32'hCAFEF00D) begin
            errors++; $display("FAIL pause_ram got %h want cafef00d",
                {ram[16'h403], ram[16'h402], ram[16'h401], ram[16'h400]});
        end
        rst_at = 1;
        txn(1'b1, 1'b1, 32'h2000, 2'b10, 32'h11223344);
        rst_at = -1;
        vectors++;
        if (lat !== -1 || w_log.size() !== 2 || mem_wr !== 1'b0) begin
            errors++; $display("FAIL rst_abort got lat=%0d writes=%0d wr=%b want -1 2 0", lat, w_log.size(), mem_wr);
        end
        txn(1'b1, 1'b1, 32'h2100, 2'b01, 32'h0000A5C3);
        ref_store(32'h2100, 2, 32'h0000A5C3);
        txn(1'b1, 1'b0, 32'h2100, 2'b01, 32'h0);
        vectors++;
        if (lat !== 3 || res !== 32'h0000A5C3) begin
            errors++; $display("FAIL rst_recover got lat=%0d data=%h want 3 0000a5c3", lat, res);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++) poke(16'(i), 8'($urandom));
        for (int it = 0; it < 60; it++) begin
            int          kind = $urandom_range(0, 2);
            logic [31:0] a    = 32'($urandom_range(0, 60));
            logic [1:0]  sz   = 2'($urandom_range(0, 3));
            logic [31:0] d    = $urandom;
            int          n    = (kind == 0) ? 4 : nbytes(sz);
            logic [31:0] want = ref_load(a, n);
            int          wlat = (kind == 2) ? n : n + 1;
            txn(kind != 0, kind == 2, a, sz, d);
            if (kind == 2) ref_store(a, n, d);
            vectors++;
            if (lat !== wlat || acc_ok !== 1'b1) begin
                errors++; $display("FAIL rand%0d_latency got %0d acc=%b want %0d 1", it, lat, acc_ok, wlat);
            end
            if (kind != 2) begin
                vectors++;
                if (res !== want) begin errors++; $display("FAIL rand%0d_data got %h want %h", it, res, want); end
            end
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end
        for (int i = 0; i < 64; i++) begin
            vectors++;
            if (ram[16'(i)] !== ref_mem[16'(i)]) begin
                errors++; $display("FAIL rand_ram%0d got %h want %h", i, ram[16'(i)], ref_mem[16'(i)]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; poke_en = 1'b0;
        poke_a = '0; poke_d = '0;
        icache_to_memctrl = 1'b0; address = '0;
        lsb_to_memctrl = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_size = '0; lsb_data = '0;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_arbitration();
        test_store_word();
        test_io_stall();
        test_wrap();
        test_pause_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
